// File: rtl/mfp_uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first serialiser, 8N1 by default.
// Define MFP_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module mfp_uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               UART_TX,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef MFP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state;
  state_t          state_nx;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            line_nx;
  logic            bit_end;
  logic            pop;
  logic            push;
  logic            fifo_nonempty;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      head;

`ifdef MFP_UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  assign tx_ready      = (count < FULL_CNT);
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (count != '0);
  assign fifo_count    = count;
  assign busy          = (state != S_IDLE) || fifo_nonempty;
  assign bit_end       = (baud_cnt == BAUD_LAST);
  assign head          = mem[rd_ptr];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Full/empty is decided by count alone; pointers simply wrap.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (fifo_nonempty) state_nx = S_START;
      end
      S_START: begin
        if (bit_end) state_nx = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef MFP_UART_TX_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_STOP;
`endif
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_nx = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_nx = fifo_nonempty ? S_START : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: next line level and the FIFO pop strobe
  always_comb begin
    line_nx = 1'b1;
    pop     = 1'b0;
    unique case (state)
      S_IDLE:   pop     = fifo_nonempty;
      S_START:  line_nx = 1'b0;
      S_DATA:   line_nx = shift[0];
`ifdef MFP_UART_TX_PARITY_EN
      S_PARITY: line_nx = parity_bit;
`endif
      S_STOP:   pop     = bit_end && fifo_nonempty;
      default:  line_nx = 1'b1;
    endcase
  end

  // Baud counter restarts at every bit boundary and idles at zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if ((state == S_IDLE) || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
      if ((state == S_DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Shift register loads on pop and moves right after each data bit.
  always_ff @(posedge HCLK) begin
    if (pop) begin
      shift <= head;
    end else if ((state == S_DATA) && bit_end) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

`ifdef MFP_UART_TX_PARITY_EN
  always_ff @(posedge HCLK) begin
    if (pop) begin
      parity_bit <= ^head;
    end
  end
`endif

  // Registered line output so the pin never glitches; idles high.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      UART_TX <= 1'b1;
    end else begin
      UART_TX <= line_nx;
    end
  end

endmodule
